// File: rtl/bwn_seq_pkg.sv
// Shared types and default configuration for the BWN loop sequencer.
package bwn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int DEF_CNT_WL   = 8;
  localparam int DEF_IV       = 0;
  localparam int DEF_LSB      = 2;
  localparam int DEF_ECV      = 13;
  localparam int DEF_OUTER_WL = 8;
  localparam int DEF_PIPE_LAT = 3;

  localparam int STALL_WL     = 16;

endpackage

// File: rtl/bwn_drain_timer.sv
// Loadable down-counter; zero is high whenever the count has reached 0.
module bwn_drain_timer #(
  parameter int WL = 2
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          load,
  input  logic [WL-1:0] value,
  output logic          zero
);

  logic [WL-1:0] count;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)               count <= '0;
    else if (load)          count <= value;
    else if (count != '0)   count <= count - WL'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bwn_seq_ctrl.sv
// Outer/inner loop sequencer for the BWN accumulate datapath.
// Optional stall-cycle counter output oSTALL_CYC enabled by `define BWN_SEQ_PERF_EN.
module bwn_seq_ctrl
  import bwn_seq_pkg::*;
#(
  parameter int CNT_WL   = DEF_CNT_WL,
  parameter int IV       = DEF_IV,
  parameter int LSB      = DEF_LSB,
  parameter int ECV      = DEF_ECV,
  parameter int OUTER_WL = DEF_OUTER_WL,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSTART,
  input  logic [OUTER_WL-1:0] iOUTER_N,
  input  logic                iSTALL,
  input  logic [CNT_WL-1:0]   iCNT,
  output logic                oCNT_EN,
  output logic                oCNT_CLR,
  output logic                oACC_CLR,
  output logic                oACC_VALID,
  output logic [OUTER_WL-1:0] oOUTER_IDX,
  output logic                oBUSY,
  output logic                oDONE
`ifdef BWN_SEQ_PERF_EN
  ,
  output logic [STALL_WL-1:0] oSTALL_CYC
`endif
);

  localparam int TMR_WL = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t              state, nstate;
  logic [OUTER_WL-1:0] n_q;
  logic                accept, term, last_pass, pass_done, tmr_zero;
  logic                cnt_clr_d, acc_clr_d, busy_d, done_d;
  logic                unused_cfg;

  // IV only matters to the external counter; the low count bits are not compared.
  if (LSB > 0) begin : g_lsb
    assign unused_cfg = ^{iCNT[LSB-1:0], IV[0]};
  end else begin : g_nolsb
    assign unused_cfg = IV[0];
  end

  assign accept    = (state == IDLE) && iSTART;
  assign oCNT_EN   = (state == RUN) && !iSTALL;
  assign term      = oCNT_EN && (iCNT[CNT_WL-1:LSB] == (CNT_WL-LSB)'(ECV));
  assign pass_done = (state == DRAIN) && tmr_zero;
  assign last_pass = (oOUTER_IDX == n_q - OUTER_WL'(1));

  // The timer reaches zero PIPE_LAT cycles after TERM, so the valid pulse is a
  // decode of the registered state and timer rather than a further flop stage.
  assign oACC_VALID = pass_done;

  bwn_drain_timer #(.WL(TMR_WL)) u_drain_timer (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .load  (term),
    .value (TMR_WL'(PIPE_LAT - 1)),
    .zero  (tmr_zero)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (iSTART) nstate = (iOUTER_N == '0) ? FIN : START;
      START:   nstate = RUN;
      RUN:     if (term) nstate = DRAIN;
      DRAIN:   if (tmr_zero) nstate = last_pass ? FIN : RUN;
      FIN:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr_d = (nstate == START);
    acc_clr_d = (nstate == START) || (pass_done && !last_pass);
    busy_d    = (nstate != IDLE);
    done_d    = (nstate == FIN);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oCNT_CLR <= 1'b0;
      oACC_CLR <= 1'b0;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
    end else begin
      oCNT_CLR <= cnt_clr_d;
      oACC_CLR <= acc_clr_d;
      oBUSY    <= busy_d;
      oDONE    <= done_d;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      n_q        <= '0;
      oOUTER_IDX <= '0;
    end else if (accept) begin
      n_q        <= iOUTER_N;
      oOUTER_IDX <= '0;
    end else if (pass_done && !last_pass) begin
      oOUTER_IDX <= oOUTER_IDX + OUTER_WL'(1);
    end
  end

`ifdef BWN_SEQ_PERF_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      oSTALL_CYC <= '0;
    else if (accept)
      oSTALL_CYC <= '0;
    else if ((state == RUN) && iSTALL && (oSTALL_CYC != '1))
      oSTALL_CYC <= oSTALL_CYC + STALL_WL'(1);
  end
`endif

endmodule
